// File: rtl/cnn_align_pkg.sv
`default_nettype none
// =============================================================================
// cnn_align_pkg : sizing defaults and lane packing shared by the skew stages.
// Rev 1.0
// =============================================================================
package cnn_align_pkg;

  localparam int DEFAULT_LANE_NUM  = 9;
  localparam int DEFAULT_GROUP_NUM = 18;
  localparam int ACC_DATA_WIDTH    = 16;

  typedef logic [$clog2(DEFAULT_LANE_NUM)-1:0] cnt_t;

  // Bit offset of lane k of group g on the flat lane bus.
  function automatic int lane_offset(input int g,
                                     input int k,
                                     input int lane_num   = DEFAULT_LANE_NUM,
                                     input int data_width = ACC_DATA_WIDTH);
    return (g * lane_num + k) * data_width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/skew_delay_line.sv
`default_nettype none
// =============================================================================
// skew_delay_line : DEPTH-stage enabled shift register, plain wire when DEPTH=0.
// Rev 1.0
// =============================================================================
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = clk ^ rst ^ en;
    assign data_o      = data_i;
  end else begin : g_pipe
    logic [DEPTH-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        stage_q <= '0;
      end else if (en) begin
        stage_q[0] <= data_i;
        for (int i = 1; i < DEPTH; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign data_o = stage_q[DEPTH-1];
  end

endmodule
`default_nettype wire

// File: rtl/align_reg_out.sv
`default_nettype none
// =============================================================================
// align_reg_out : output de-skew, lane k delayed LANE_NUM-1-k en cycles.
// Option macro ALIGN_OUT_SKEW_CHECK_EN builds the lane_valid timing check. Rev 1.0
// =============================================================================
module align_reg_out
  import cnn_align_pkg::*;
#(
  parameter int LANE_NUM    = DEFAULT_LANE_NUM,
  parameter int GROUP_NUM   = DEFAULT_GROUP_NUM,
  parameter int DATA_WIDTH  = ACC_DATA_WIDTH,
  parameter int TOTAL_WIDTH = LANE_NUM * GROUP_NUM * DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   in_valid,
  input  logic                   in_last,
  input  logic [TOTAL_WIDTH-1:0] in_data,
  input  logic [LANE_NUM-1:0]    lane_valid,
  output logic                   out_valid,
  output logic                   out_last,
  output logic [TOTAL_WIDTH-1:0] out_data,
  output logic                   busy,
  output logic                   skew_err
);

  localparam int LANE_W = GROUP_NUM * DATA_WIDTH;
  localparam int SKEW   = LANE_NUM - 1;
  localparam int CNT_W  = (LANE_NUM > 1) ? $clog2(LANE_NUM) : 1;
  localparam logic [CNT_W:0] CNT_MAX = (CNT_W+1)'(SKEW);

  logic [LANE_NUM-1:0][LANE_W-1:0] lane_in;
  logic [LANE_NUM-1:0][LANE_W-1:0] lane_out;

  // One delay line per lane carries that lane for every group at once.
  always_comb begin
    lane_in  = '0;
    out_data = '0;
    for (int g = 0; g < GROUP_NUM; g++) begin
      for (int k = 0; k < LANE_NUM; k++) begin
        lane_in[k][g*DATA_WIDTH +: DATA_WIDTH] =
          in_data[lane_offset(g, k, LANE_NUM, DATA_WIDTH) +: DATA_WIDTH];
        out_data[lane_offset(g, k, LANE_NUM, DATA_WIDTH) +: DATA_WIDTH] =
          lane_out[k][g*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  for (genvar k = 0; k < LANE_NUM; k++) begin : g_lane
    skew_delay_line #(
      .DEPTH (SKEW - k),
      .WIDTH (LANE_W)
    ) u_lane_dly (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .data_i (lane_in[k]),
      .data_o (lane_out[k])
    );
  end

  logic [1:0] ctl_in;
  logic [1:0] ctl_out;

  assign ctl_in = {in_valid & in_last, in_valid};

  skew_delay_line #(
    .DEPTH (SKEW),
    .WIDTH (2)
  ) u_ctl_dly (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .data_i (ctl_in),
    .data_o (ctl_out)
  );

  assign out_valid = ctl_out[0];
  assign out_last  = ctl_out[1];

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W:0]   cnt_calc;

  assign cnt_calc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, in_valid} - {{CNT_W{1'b0}}, out_valid};
  assign cnt_d    = en ? cnt_calc[CNT_W-1:0] : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0) | out_valid;

  // A wrap here (either direction) means beats were injected faster than the pipe drains.
  a_cnt_bound : assert property (@(posedge clk) disable iff (rst) en |-> (cnt_calc <= CNT_MAX));

`ifdef ALIGN_OUT_SKEW_CHECK_EN
  logic [SKEW-1:0]     ref_q;
  logic [LANE_NUM-1:0] ref_exp;
  logic                skew_err_q;

  // Bit k of ref_exp is in_valid as it was k en cycles ago.
  assign ref_exp = {ref_q, in_valid};

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q      <= '0;
      skew_err_q <= 1'b0;
    end else if (en) begin
      ref_q <= ref_exp[SKEW-1:0];
      if (lane_valid != ref_exp) begin
        skew_err_q <= 1'b1;
      end
    end
  end

  assign skew_err = skew_err_q;
`else
  logic unused_lane_valid;
  assign unused_lane_valid = ^lane_valid;
  assign skew_err          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_align_reg_out.sv
`default_nettype none
// =============================================================================
// tb_align_reg_out : directed and random checks of align_reg_out against an
// en-cycle history model. Rev 1.0
// =============================================================================
module tb_align_reg_out;
  import cnn_align_pkg::*;

  localparam int L  = DEFAULT_LANE_NUM;
  localparam int G  = DEFAULT_GROUP_NUM;
  localparam int DW = ACC_DATA_WIDTH;
  localparam int TW = L * G * DW;

`ifdef ALIGN_OUT_SKEW_CHECK_EN
  localparam bit CHECK_ON = 1'b1;
`else
  localparam bit CHECK_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          in_valid;
  logic          in_last;
  logic [TW-1:0] in_data;
  logic [L-1:0]  lane_valid;
  logic          out_valid;
  logic          out_last;
  logic [TW-1:0] out_data;
  logic          busy;
  logic          skew_err;

  align_reg_out dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_data    (in_data),
    .lane_valid (lane_valid),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_data   (out_data),
    .busy       (busy),
    .skew_err   (skew_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: inputs accepted on the last L-1 en cycles, index 0 = most recent.
  typedef struct packed {
    logic          v;
    logic          l;
    logic [TW-1:0] d;
  } beat_t;

  beat_t hq[$];
  logic  exp_skew = 1'b0;
  bit    model_ok = 1'b0;

  function automatic logic [DW-1:0] lane_of(input logic [TW-1:0] bus, input int g, input int k);
    return bus[(g*L + k)*DW +: DW];
  endfunction

  // Lane k of the output word was sampled L-1-k en cycles ago; the last lane is live.
  function automatic logic [TW-1:0] exp_data();
    logic [TW-1:0] r;
    logic [TW-1:0] src;
    r = '0;
    for (int k = 0; k < L; k++) begin
      if (k == L-1) src = in_data;
      else          src = hq[L-2-k].d;
      for (int g = 0; g < G; g++) r[(g*L + k)*DW +: DW] = src[(g*L + k)*DW +: DW];
    end
    return r;
  endfunction

  function automatic logic [L-1:0] ref_lv();
    logic [L-1:0] r;
    r[0] = in_valid;
    for (int k = 1; k < L; k++) r[k] = hq[k-1].v;
    return r;
  endfunction

  function automatic logic any_inflight();
    logic r;
    r = 1'b0;
    for (int i = 0; i < L-1; i++) r = r | hq[i].v;
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      hq.delete();
      for (int i = 0; i < L-1; i++) hq.push_back('0);
      exp_skew = 1'b0;
      model_ok = 1'b1;
    end else if (en && model_ok) begin
      if (CHECK_ON && (lane_valid != ref_lv())) exp_skew = 1'b1;
      hq.push_front('{v: in_valid, l: in_valid & in_last, d: in_data});
      void'(hq.pop_back());
    end
  end

  task automatic checkv(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
    end
  endtask

  task automatic check_data(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      for (int i = 0; i < G*L; i++) begin
        if (act[i*DW +: DW] !== exp[i*DW +: DW]) begin
          $display("FAIL %s t=%0t group=%0d lane=%0d got=%h want=%h", name, $time,
                   i / L, i % L, act[i*DW +: DW], exp[i*DW +: DW]);
          break;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      checkv("out_valid", 32'(out_valid), 32'(hq[L-2].v));
      checkv("out_last", 32'(out_last), 32'(hq[L-2].l));
      checkv("busy", 32'(busy), 32'(any_inflight()));
      checkv("skew_err", 32'(skew_err), 32'(exp_skew));
      check_data("out_data", out_data, exp_data());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int k, input logic [DW-1:0] v);
    for (int g = 0; g < G; g++) in_data[(g*L + k)*DW +: DW] = v;
  endtask

  task automatic idle_inputs();
    en         = 1'b1;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    in_data    = '0;
    lane_valid = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // 20 beats, beat n lane k = n*16+k; lane k of beat n offered on en cycle n+k.
  task automatic run_stream(input int stall_at, input int stall_len, input int exp_first,
                            input string tag);
    int e = 0;
    int first = -1;
    int nvalid = 0;
    int nlast = 0;
    int last_beat = -1;
    int busy_fall = -1;
    do_reset();
    for (int c = 0; c < 45; c++) begin
      en      = !(c >= stall_at && c < stall_at + stall_len);
      in_data = '0;
      for (int k = 0; k < L; k++) begin
        if (e - k >= 0 && e - k < 20) set_lane(k, 16'((e - k) * 16 + k));
      end
      in_valid   = (e < 20);
      in_last    = (e == 19);
      lane_valid = ref_lv();
      #1;
      if (out_valid && first < 0) first = c;
      if (out_valid && en) begin
        checkv({tag, "_order_l0"}, 32'(lane_of(out_data, 3, 0)), 32'(nvalid * 16));
        checkv({tag, "_order_l8"}, 32'(lane_of(out_data, G-1, L-1)), 32'(nvalid * 16 + L - 1));
        if (out_last) begin
          nlast++;
          last_beat = nvalid;
        end
        nvalid++;
      end
      if (first >= 0 && busy_fall < 0 && !busy) busy_fall = c;
      tick();
      if (en) e++;
    end
    checkv({tag, "_first"}, 32'(first), 32'(exp_first));
    checkv({tag, "_count"}, 32'(nvalid), 32'd20);
    checkv({tag, "_nlast"}, 32'(nlast), 32'd1);
    checkv({tag, "_lastbeat"}, 32'(last_beat), 32'd19);
    checkv({tag, "_busyfall"}, 32'(busy_fall), 32'(exp_first + 20));
  endtask

  initial begin
    logic [L-1:0] lv;
    int nv;

    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checkv("rst_out_valid", 32'(out_valid), 32'd0);
    checkv("rst_out_last", 32'(out_last), 32'd0);
    checkv("rst_busy", 32'(busy), 32'd0);
    checkv("rst_skew_err", 32'(skew_err), 32'd0);
    check_data("rst_out_data", out_data, '0);

    // Single beat
    do_reset();
    for (int c = 0; c < 11; c++) begin
      in_data = '0;
      if (c < L) set_lane(c, 16'(16'h0100 + c));
      in_valid   = (c == 0);
      in_last    = 1'b0;
      lane_valid = ref_lv();
      #1;
      if (c == L-2) checkv("single_early", 32'(out_valid), 32'd0);
      if (c == L-1) begin
        checkv("single_valid", 32'(out_valid), 32'd1);
        for (int k = 0; k < L; k++) begin
          checkv("single_g0", 32'(lane_of(out_data, 0, k)), 32'(16'h0100 + k));
          checkv("single_g17", 32'(lane_of(out_data, G-1, k)), 32'(16'h0100 + k));
        end
      end
      if (c == L) begin
        checkv("single_late", 32'(out_valid), 32'd0);
        checkv("single_busy", 32'(busy), 32'd0);
      end
      tick();
    end

    run_stream(1000, 0, 8, "stream");
    run_stream(3, 3, 11, "stall");

    // Reset four cycles into a tile
    do_reset();
    nv = 0;
    for (int c = 0; c < 20; c++) begin
      in_data = '0;
      for (int k = 0; k < L; k++) begin
        if (c - k >= 0 && c - k < 4) set_lane(k, 16'(16'h0200 + (c - k) * 16 + k));
      end
      in_valid   = (c < 4);
      in_last    = 1'b0;
      rst        = (c == 4);
      lane_valid = ref_lv();
      #1;
      if (c > 4 && out_valid) nv++;
      if (c == 5) checkv("midrst_busy", 32'(busy), 32'd0);
      tick();
    end
    rst = 1'b0;
    checkv("midrst_no_valid", 32'(nv), 32'd0);

    // lane_valid[5] one en cycle early
    do_reset();
    for (int c = 0; c < 14; c++) begin
      in_data    = '0;
      in_valid   = (c == 0);
      in_last    = 1'b0;
      lv         = ref_lv();
      lv[5]      = (c == 4);
      lane_valid = lv;
      #1;
      if (c == 4) checkv("skew_before", 32'(skew_err), 32'd0);
      if (c == 5) checkv("skew_set", 32'(skew_err), 32'(CHECK_ON));
      if (c == 13) checkv("skew_held", 32'(skew_err), 32'(CHECK_ON));
      tick();
    end
    do_reset();
    #1;
    checkv("skew_cleared", 32'(skew_err), 32'd0);

    // Random traffic
    do_reset();
    for (int c = 0; c < 2500; c++) begin
      rst      = ($urandom_range(0, 199) == 0);
      en       = ($urandom_range(0, 9) != 0);
      in_valid = ($urandom_range(0, 9) < 6);
      in_last  = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < TW/32; i++) in_data[i*32 +: 32] = $urandom();
      lv = ref_lv();
      if ($urandom_range(0, 399) == 0) lv[$urandom_range(0, L-1)] ^= 1'b1;
      lane_valid = lv;
      tick();
    end
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
